cnn_layer_sequencer: RTL
========================

Name: cnn_layer_sequencer

Overview:
- Top-level scheduler for the CNN inference pipeline.
- Launches each layer engine in order: convolution, pooling, dense and similar engines that each expose a start input and a level done/idle output.
- Waits for each engine to complete, then swaps the ping-pong feature-memory bank between layers.
- Reports frame completion, or a per-layer watchdog timeout, to the host-side interface.

Parameters:
- NUM_LAYERS, 4, number of engines sequenced, in order 0..NUM_LAYERS-1 (≥1).
- IDX_WIDTH, 2, width of the layer index; must satisfy 2^IDX_WIDTH ≥ NUM_LAYERS.
- TMO_WIDTH, 24, width of the watchdog cycle counter.
- TMO_CYCLES, 24'd10000000, per-layer cycle limit; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- in_start  in  1  frame request; sampled only in IDLE.
- in_abort  in  1  abandon the current frame; highest priority.
- out_busy  out  1  high in every state except IDLE.
- out_done  out  1  one-cycle pulse when the frame completes.
- out_timeout  out  1  high while in ERROR.
- out_layerStart  out  NUM_LAYERS  one-hot start, bit k drives engine k.
- in_layerDone  in  NUM_LAYERS  bit k = engine k level done (high while that engine is idle).
- out_layerIdx  out  IDX_WIDTH  index of the active layer.
- out_bankSel  out  1  bank read by the active layer; the layer writes bank ~out_bankSel.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, idx=0, bankSel=0, timer=0.
  - All outputs 0 the cycle after reset.
  - Reset mid-frame drops out_layerStart immediately; engines are not reset by this block.
- States: IDLE, LAUNCH, RUN, NEXT, FINISH, ERROR. All outputs are Moore, decoded from registered state, idx and bankSel.
- IDLE: in_start=1 → LAUNCH, with idx←0, bankSel←0, timer←0.
- LAUNCH:
  - out_layerStart[idx]=1.
  - When in_layerDone[idx]=0 (engine has left idle) → RUN.
  - Start stays high at least 1 cycle and until the engine acknowledges; this handles engines whose done is already high while idle.
- RUN:
  - out_layerStart all 0.
  - in_layerDone[idx]=1 → NEXT.
- NEXT (exactly 1 cycle):
  - bankSel←~bankSel.
  - If idx==NUM_LAYERS-1 → FINISH; else idx←idx+1, timer←0, → LAUNCH.
- FINISH (1 cycle): out_done=1, → IDLE.
  - idx and bankSel hold in IDLE.
  - out_bankSel in IDLE after a frame = NUM_LAYERS mod 2, which is the bank holding the final result.
- Watchdog:
  - timer increments each cycle in LAUNCH or RUN and saturates at all-ones.
  - If TMO_CYCLES≠0 and timer==TMO_CYCLES-1 while still in LAUNCH/RUN → ERROR.
  - Timeout takes priority over a same-cycle done/acknowledge.
- ERROR: out_timeout=1, out_busy=1, starts 0. Leaves only on in_abort=1 → IDLE.
- in_abort=1 in any non-IDLE state → IDLE next cycle.
  - out_done is not pulsed; idx and bankSel are cleared to 0.
  - Abort beats every other transition. In IDLE, abort is ignored and beats a same-cycle in_start.
- in_start outside IDLE is ignored; it is not queued.
  - in_start held high through FINISH starts a new frame on the first IDLE cycle: done pulse, then 1 IDLE cycle, then LAUNCH.
- Minimum frame latency with zero-length engines: NUM_LAYERS×3+2 cycles from in_start to out_done.
- Index and done lookups use idx directly; out-of-range idx is unreachable.

Decomposition:
- Shared package cnn_pkg holds:
  - state encoding localparams (IDLE=0 … ERROR=5, STATE_BITS=3);
  - IDX_WIDTH / TMO_WIDTH defaults;
  - the bank-select convention (0 = bank A).
- One sub-module: cnn_seq_watchdog (clear, en, limit → expired), built on the existing saturating Counter style.
- Everything else is the FSM in this module.

Test Plan:
- Normal frame (NUM_LAYERS=3, engines acknowledge 1 cycle after start, run 5 cycles): in_start pulse →
  - out_layerStart = 001, 010, 100 in order;
  - out_bankSel = 0, 1, 0 during layers 0, 1, 2;
  - single out_done pulse; final out_bankSel=1; out_busy low after.
- Slow acknowledge (engine 1 holds done high 4 cycles after start) → out_layerStart[1] stays high 5 cycles, then RUN; no skipped layer.
- Timeout (TMO_CYCLES=20, engine 2 never reasserts done) → ERROR on cycle 20 of layer 2 with out_timeout=1; in_start ignored; in_abort → IDLE, out_timeout=0, out_bankSel=0.
- Abort mid-RUN of layer 1 → next cycle out_busy=0, starts 0, no out_done; a fresh in_start restarts at layer 0, bank 0.
- Synchronous reset asserted during LAUNCH → outputs 0 after the edge (not before); behaviour identical to power-up.
- Busy-time start: in_start held high through a whole frame →
  - exactly one frame per IDLE visit;
  - back-to-back frames separated by done pulse + 1 IDLE cycle;
  - TMO_CYCLES=0 with a 100k-cycle engine → no timeout.

Source files
------------

// File: rtl/cnn_layer_sequencer_pkg.sv
// Shared definitions for the CNN layer sequencer: state encoding,
// default widths and the feature-memory bank naming.
package cnn_pkg;

  // Sequencer state encoding
  localparam int STATE_BITS = 3;
  typedef logic [STATE_BITS-1:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t LAUNCH = 3'd1;
  localparam state_t RUN    = 3'd2;
  localparam state_t NEXT   = 3'd3;
  localparam state_t FINISH = 3'd4;
  localparam state_t ERROR  = 3'd5;

  // Default widths for the layer index and the watchdog counter
  localparam int DEF_IDX_WIDTH = 2;
  localparam int DEF_TMO_WIDTH = 24;

  // Bank-select convention: 0 selects bank A for reading
  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Host/engine-side signal bundle of the layer sequencer.
// master = sequencer side, slave = host/engine side.
interface cnn_layer_sequencer_if
  import cnn_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH
);
  logic                  in_start;
  logic                  in_abort;
  logic                  out_busy;
  logic                  out_done;
  logic                  out_timeout;
  logic [NUM_LAYERS-1:0] out_layerStart;
  logic [NUM_LAYERS-1:0] in_layerDone;
  logic [IDX_WIDTH-1:0]  out_layerIdx;
  logic                  out_bankSel;

  modport master (
    input  in_start, in_abort, in_layerDone,
    output out_busy, out_done, out_timeout, out_layerStart, out_layerIdx, out_bankSel
  );

  modport slave (
    output in_start, in_abort, in_layerDone,
    input  out_busy, out_done, out_timeout, out_layerStart, out_layerIdx, out_bankSel
  );
endinterface

// File: rtl/cnn_layer_sequencer_watchdog.sv
// Per-layer watchdog: a saturating cycle counter that flags expiry when
// it reaches limit-1 while enabled. A zero limit disables expiry.
module cnn_seq_watchdog
  import cnn_pkg::*;
#(
  parameter int WIDTH = DEF_TMO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             expired_o
);
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise count up and stick at all-ones
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !(&count_q)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is only meaningful while counting and with a non-zero limit
  always_comb begin
    expired_o = en_i && (limit_i != '0) && (count_q == (limit_i - WIDTH'(1)));
  end
endmodule

// File: rtl/cnn_layer_sequencer.sv
// Top-level CNN layer scheduler: launches engines 0..NUM_LAYERS-1 in turn,
// waits for each to finish, flips the ping-pong bank between layers and
// reports frame completion or a per-layer watchdog timeout.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int                   NUM_LAYERS = 4,
  parameter int                   IDX_WIDTH  = DEF_IDX_WIDTH,
  parameter int                   TMO_WIDTH  = DEF_TMO_WIDTH,
  parameter logic [TMO_WIDTH-1:0] TMO_CYCLES = TMO_WIDTH'(10000000)
) (
  input logic                   clk,
  input logic                   rst_n,
  cnn_layer_sequencer_if.master bus
);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_LAYERS - 1);

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  bank_q, bank_d;
  logic [NUM_LAYERS-1:0] idx_hot;
  logic                  done_cur;
  logic                  wdg_clear;
  logic                  wdg_en;
  logic                  wdg_expired;

  // One-hot decode of the active layer index; drives both the start
  // vector and the done lookup so no variable bit-select is needed
  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_idx_hot
      assign idx_hot[gi] = (idx_q == IDX_WIDTH'(gi));
    end
  endgenerate

  assign done_cur  = |(bus.in_layerDone & idx_hot);
  assign wdg_en    = (state_q == LAUNCH) || (state_q == RUN);
  // Timer restarts whenever a layer is about to be launched
  assign wdg_clear = (state_q == IDLE) || (state_q == NEXT);

  cnn_seq_watchdog #(
    .WIDTH (TMO_WIDTH)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (wdg_clear),
    .en_i      (wdg_en),
    .limit_i   (TMO_CYCLES),
    .expired_o (wdg_expired)
  );

  // State, layer index and bank registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bank_q  <= BANK_A;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bank_q  <= bank_d;
    end
  end

  // Next-state logic; abort overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bank_d  = bank_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_start && !bus.in_abort) begin
          state_d = LAUNCH;
          idx_d   = '0;
          bank_d  = BANK_A;
        end
      end
      LAUNCH: begin
        // Keep start asserted until the engine drops its done level
        if (wdg_expired)    state_d = ERROR;
        else if (!done_cur) state_d = RUN;
      end
      RUN: begin
        if (wdg_expired)   state_d = ERROR;
        else if (done_cur) state_d = NEXT;
      end
      NEXT: begin
        bank_d = ~bank_q;
        if (idx_q == LAST_IDX) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + IDX_WIDTH'(1);
          state_d = LAUNCH;
        end
      end
      FINISH: state_d = IDLE;
      ERROR:  state_d = ERROR;
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        bank_d  = BANK_A;
      end
    endcase
    if (bus.in_abort && (state_q != IDLE)) begin
      state_d = IDLE;
      idx_d   = '0;
      bank_d  = BANK_A;
    end
  end

  // Moore output decode from registered state, index and bank
  always_comb begin
    bus.out_busy       = (state_q != IDLE);
    bus.out_done       = (state_q == FINISH);
    bus.out_timeout    = (state_q == ERROR);
    bus.out_layerStart = (state_q == LAUNCH) ? idx_hot : '0;
    bus.out_layerIdx   = idx_q;
    bus.out_bankSel    = bank_q;
  end
endmodule
